// File: rtl/serial_add_sub.sv
// serial_add_sub
// Digit-serial adder/subtractor. Each clock consumes DIGIT bits of the latched
// operands through a small ripple of full adders and a registered carry. The
// result is assembled in a shift register and published with a one-cycle done
// pulse after WIDTH/DIGIT clocks.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start, outputs hold the last result
//   RUN   | one digit per clock, busy=1
//   DONE  | done=1 for this cycle; start here is accepted back-to-back
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("serial_add_sub: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;

    logic [DIGIT-1:0] dig_sum;
    logic [DIGIT:0]   c_chain;
    logic [WIDTH-1:0] res_next;

    // Ripple of DIGIT full adders over the low digit of the shifted operands.
    always_comb begin
        c_chain    = '0;
        dig_sum    = '0;
        c_chain[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dig_sum[i]   = a_sh[i] ^ b_sh[i] ^ c_chain[i];
            c_chain[i+1] = (a_sh[i] & b_sh[i]) | (c_chain[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    // New digit enters at the MSB end; after N steps the register holds the
    // result with digit 0 at the bottom.
    generate
        if (DIGIT < WIDTH) begin : g_shift
            assign res_next = {dig_sum, res[WIDTH-1:DIGIT]};
        end else begin : g_full
            assign res_next = dig_sum;
        end
    endgenerate

    // Control FSM, operand shifters, carry and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction as a + ~b + 1; borrow-in removes the +1.
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= c_in ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    res   <= res_next;
                    carry <= c_chain[DIGIT];
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        c_out <= c_chain[DIGIT];
                        // The top bit of the last digit is bit WIDTH-1.
                        ovf   <= c_chain[DIGIT-1] ^ c_chain[DIGIT];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: a WIDTH=8/DIGIT=1 unit and a
// WIDTH=8/DIGIT=4 unit sharing clock and reset.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start1 = 1'b0, sub1 = 1'b0, c_in1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0;
    logic       busy1, done1, c_out1, ovf1;
    logic [7:0] sum1;

    logic       start4 = 1'b0, sub4 = 1'b0, c_in4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, c_out4, ovf4;
    logic [7:0] sum4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .c_in(c_in1), .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1), .ovf(ovf1)
    );

    serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .c_in(c_in4), .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4), .ovf(ovf4)
    );

    // {sub, c_in, a, b, sum, c_out, ovf}
    logic [27:0] vec [7] = '{
        {1'b0, 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1},
        {1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0},
        {1'b0, 1'b1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1},
        {1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0},
        {1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1},
        {1'b1, 1'b1, 8'h10, 8'h05, 8'h0A, 1'b1, 1'b0},
        {1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1}
    };

    // Issue one op on the DIGIT=1 unit and return clocks from start edge to done.
    task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, output int lat);
        @(negedge clk);
        start1 = 1'b1; sub1 = s; a1 = av; b1 = bv; c_in1 = ci;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy1, done1, sum1, c_out1, ovf1} !== 12'h000) begin
            fails++;
            $display("FAIL reset_d1: got %h expected 000", {busy1, done1, sum1, c_out1, ovf1});
        end
        tests++;
        if ({busy4, done4, sum4, c_out4, ovf4} !== 12'h000) begin
            fails++;
            $display("FAIL reset_d4: got %h expected 000", {busy4, done4, sum4, c_out4, ovf4});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(vec[i][27], vec[i][25:18], vec[i][17:10], vec[i][26], lat);
            tests++;
            if (lat !== 8) begin
                fails++;
                $display("FAIL arith%0d_latency: got %0d expected 8", i, lat);
            end
            tests++;
            if (sum1 !== vec[i][9:2]) begin
                fails++;
                $display("FAIL arith%0d_sum: got %h expected %h", i, sum1, vec[i][9:2]);
            end
            tests++;
            if (c_out1 !== vec[i][1]) begin
                fails++;
                $display("FAIL arith%0d_c_out: got %b expected %b", i, c_out1, vec[i][1]);
            end
            tests++;
            if (ovf1 !== vec[i][0]) begin
                fails++;
                $display("FAIL arith%0d_ovf: got %b expected %b", i, ovf1, vec[i][0]);
            end
            @(negedge clk);
            tests++;
            if ({done1, busy1} !== 2'b00) begin
                fails++;
                $display("FAIL arith%0d_done_pulse: got done,busy=%b expected 00", i, {done1, busy1});
            end
        end
    endtask

    task automatic test_digit4();
        int lat;
        @(negedge clk);
        start4 = 1'b1; sub4 = 1'b0; a4 = 8'h0F; b4 = 8'h01; c_in4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        tests++;
        if ({busy4, done4} !== 2'b10) begin
            fails++;
            $display("FAIL d4_busy: got busy,done=%b expected 10", {busy4, done4});
        end
        lat = 0;
        while (done4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL d4_latency: got %0d expected 2", lat);
        end
        tests++;
        if ({sum4, c_out4, ovf4} !== {8'h10, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL d4_result: got %h/%b/%b expected 10/0/0", sum4, c_out4, ovf4);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        // Previous result from test_arith is sum=00 c_out=1 ovf=1.
        @(negedge clk);
        start1 = 1'b1; sub1 = 1'b0; a1 = 8'h01; b1 = 8'h02; c_in1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        start1 = 1'b1; sub1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF; c_in1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        tests++;
        if ({sum1, c_out1, ovf1, busy1} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL hold_mid_run: got sum=%h c=%b v=%b busy=%b expected 00/1/1/1",
                     sum1, c_out1, ovf1, busy1);
        end
        lat = 3;
        while (done1 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL ignore_latency: got %0d expected 8", lat);
        end
        tests++;
        if ({sum1, c_out1, ovf1} !== {8'h03, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL ignore_result: got %h/%b/%b expected 03/0/0", sum1, c_out1, ovf1);
        end
        @(negedge clk);
        tests++;
        if ({busy1, done1} !== 2'b00) begin
            fails++;
            $display("FAIL ignore_idle: got busy,done=%b expected 00", {busy1, done1});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(1'b0, 8'h12, 8'h34, 1'b0, lat);
        tests++;
        if (sum1 !== 8'h46 || lat !== 8) begin
            fails++;
            $display("FAIL b2b_first: got sum=%h lat=%0d expected 46 lat=8", sum1, lat);
        end
        // Still in the done cycle: present the next op now.
        start1 = 1'b1; sub1 = 1'b1; a1 = 8'hC8; b1 = 8'h64; c_in1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        tests++;
        if ({busy1, done1} !== 2'b10) begin
            fails++;
            $display("FAIL b2b_accept: got busy,done=%b expected 10", {busy1, done1});
        end
        lat = 0;
        while (done1 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL b2b_latency: got %0d expected 8", lat);
        end
        tests++;
        if ({sum1, c_out1, ovf1} !== {8'h64, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL b2b_second: got %h/%b/%b expected 64/1/1", sum1, c_out1, ovf1);
        end
        @(negedge clk);
    endtask

    task automatic test_midrun_reset();
        int lat;
        int seen_done;
        @(negedge clk);
        start1 = 1'b1; sub1 = 1'b0; a1 = 8'h5A; b1 = 8'h33; c_in1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy1, done1, sum1, c_out1, ovf1} !== 12'h000) begin
            fails++;
            $display("FAIL abort_outputs: got %h expected 000", {busy1, done1, sum1, c_out1, ovf1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done1 === 1'b1 || busy1 === 1'b1) seen_done++;
        end
        tests++;
        if (seen_done !== 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done);
        end
        run_op(1'b0, 8'h5A, 8'h33, 1'b0, lat);
        tests++;
        if ({sum1, c_out1, ovf1} !== {8'h8D, 1'b0, 1'b1} || lat !== 8) begin
            fails++;
            $display("FAIL abort_recover: got %h/%b/%b lat=%0d expected 8D/0/1 lat=8",
                     sum1, c_out1, ovf1, lat);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_digit4();
        test_start_ignored();
        test_back_to_back();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
